ivector_initiator: RTL
======================

// Module: ivector_initiator
// PURPOSE
// - Client-side traffic initiator and checker for the IVector request/indication protocol.
// - Drives say(meth, v) requests into an IVector server, spread round-robin over NUM_LANES lanes.
// - Accepts the heard(meth, v) indications that come back and checks per-lane ordering and payload.
// - Used as the self-checking bench/BIST partner of the lane-vector FIFO block.
// PARAMETERS
// - NUM_LANES    10  number of lanes (meth values 0..NUM_LANES-1)
// - IDX_WIDTH    4   width of meth; must satisfy 2**IDX_WIDTH >= NUM_LANES
// - DATA_WIDTH   32  width of say$v / heard$v
// - COUNT_WIDTH  16  width of per-lane message counters and num_msgs
// - TIMEOUT      1024  max idle cycles allowed in DRAIN before a timeout error
// PORTS
// - CLK           in   1            clock
// - nRST          in   1            reset; synchronous, active-low
// - start         in   1            pulse: begin a run (ignored unless state is IDLE or DONE)
// - num_msgs      in   COUNT_WIDTH  messages per lane for this run; sampled on start
// - say__ENA      out  1            request valid; asserted only when say__RDY=1
// - say__RDY      in   1            server can accept a request
// - say$meth      out  IDX_WIDTH    lane index of the request
// - say$v         out  DATA_WIDTH   payload {lane[7:0], seq[DATA_WIDTH-9:0]}
// - heard__ENA    in   1            indication valid; the server drives it only when heard__RDY=1
// - heard__RDY    out  1            initiator can accept an indication
// - heard$meth    in   IDX_WIDTH    lane index of the indication
// - heard$v       in   DATA_WIDTH   indication payload
// - busy          out  1            run in progress (SEND or DRAIN)
// - done          out  1            run finished; held high until the next start
// - err_count     out  COUNT_WIDTH  mismatch + timeout count; saturates at all-ones
// - first_err_lane out IDX_WIDTH    lane of the first error in this run
// BEHAVIOUR
// - Reset: state=IDLE; all counters=0; say__ENA, heard__RDY, busy, done=0; err_count=0; first_err_lane=0.
// - FSM: IDLE -start-> SEND; SEND -all lanes sent==num_msgs-> DRAIN; DRAIN -all recv==sent-> DONE.
// - FSM: DRAIN -TIMEOUT cycles with no heard-> DONE, +1 error; DONE -start-> SEND.
// - start with num_msgs=0: SEND->DRAIN->DONE on consecutive cycles; no requests issued.
// - A start pulse while busy=1 is ignored.
// - Run start clears the sent/recv/exp_seq counters, err_count and first_err_lane.
// - Request issue in SEND:
//   - a round-robin arbiter picks the next lane after last_granted with sent[l] < num_msgs;
//   - say__ENA = (state==SEND) && any lane eligible && say__RDY (combinational, same cycle);
//   - on fire: sent[l]++ and last_granted<=l; seq = sent[l] before the increment, zero-extended.
// - Response accept: heard__RDY=1 in SEND or DRAIN, 0 in IDLE/DONE. On heard__ENA, with l=heard$meth:
//   - error if l >= NUM_LANES;
//   - error if recv[l] == sent[l] (unsolicited indication);
//   - error if heard$v != {l[7:0], exp_seq[l]};
//   - otherwise, and also after any error on a valid lane, recv[l]++ and exp_seq[l]++.
// - A say fire and a heard accept in the same cycle are both processed; recv compares against the pre-update sent.
// - At most one error is counted per cycle; first_err_lane is latched only while err_count==0.
// - The DRAIN idle counter resets on every heard accept.
// - Each done rise lasts until the next start; reset mid-run returns to IDLE with no done.
// - The seq field wraps modulo 2**(DATA_WIDTH-8); comparisons wrap identically.
// CONFIGURATION
// - IVECTOR_INIT_BACKPRESSURE_EN defined:
//   - a 16-bit LFSR (seed 16'hACE1, advances every cycle) gates heard__RDY:
//     heard__RDY = base & lfsr[0], where base = (state==SEND||DRAIN);
//   - the DRAIN idle counter counts only cycles where heard__RDY=1.
// - Macro undefined: heard__RDY = base; no LFSR logic is instantiated.
// STRUCTURE
// - ivector_init_pkg holds: the state_t enum (IDLE, SEND, DRAIN, DONE); the LANE_TAG_W=8 constant;
//   and function pack_payload(lane, seq).
// - Sub-module rr_arbiter #(N=NUM_LANES): inputs req vector and last grant; outputs one-hot grant,
//   grant index and any.
// - Per-lane counters (sent, recv, exp_seq) are arrays inside ivector_initiator.
// TESTING
// - Loopback to an ideal in-order echo server, num_msgs=3: 30 says, 3 per lane, lanes in RR order 0..9;
//   done=1, err_count=0.
// - Server echoes lane 4 seq1 before seq0: err_count=2, first_err_lane=4, done=1.
// - num_msgs=0, start: busy for 2 cycles, done=1, say__ENA never asserted.
// - Server drops the last lane-7 indication: DRAIN times out after TIMEOUT cycles; err_count=1;
//   first_err_lane=7.
// - heard with meth=12, then heard on an idle lane 2: err_count increments each time, saturating
//   at 16'hFFFF under a flood.
// - Macro defined, num_msgs=50: heard__RDY toggles, every handshake completes, err_count=0.
// - Any config: nRST pulled mid-SEND, then start: counters and errors start from zero.

Source files
------------

// File: rtl/ivector_init_pkg.sv
// +----------------------------------------------------------------------------+
// | ivector_init_pkg: shared types and payload packing for ivector_initiator   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package ivector_init_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int LANE_TAG_W = 8;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Lane tag sits above a seq field that wraps at DATA_WIDTH-LANE_TAG_W bits.
  function automatic logic [63:0] pack_payload(input logic [LANE_TAG_W-1:0] lane,
                                               input logic [63:0] seq,
                                               input int data_w);
    logic [63:0] mask;
    mask = (64'd1 << (data_w - LANE_TAG_W)) - 64'd1;
    return ({56'd0, lane} << (data_w - LANE_TAG_W)) | (seq & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | rr_arbiter: round-robin pick of the first requester after the last grant   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int N     = 10,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_any
);

  always_comb begin
    int j;
    j         = 0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(i_last) + k) % N;
      if (!o_any && i_req[j]) begin
        o_any     = 1'b1;
        o_gnt[j]  = 1'b1;
        o_gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ivector_initiator.sv
// +----------------------------------------------------------------------------+
// | ivector_initiator: IVector say/heard traffic initiator and ordering checker|
// | Optional IVECTOR_INIT_BACKPRESSURE_EN: LFSR-gated heard__RDY. Revision: 1.0|
// +----------------------------------------------------------------------------+
`default_nettype none

module ivector_initiator
  import ivector_init_pkg::*;
#(
  parameter int NUM_LANES   = 10,
  parameter int IDX_WIDTH   = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_msgs,
  output logic                   say__ENA,
  input  logic                   say__RDY,
  output logic [IDX_WIDTH-1:0]   say_meth,
  output logic [DATA_WIDTH-1:0]  say_v,
  input  logic                   heard__ENA,
  output logic                   heard__RDY,
  input  logic [IDX_WIDTH-1:0]   heard_meth,
  input  logic [DATA_WIDTH-1:0]  heard_v,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] err_count,
  output logic [IDX_WIDTH-1:0]   first_err_lane
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [COUNT_WIDTH-1:0] c_cnt_one = COUNT_WIDTH'(1);

  state_t r_state, w_state_nxt;
  logic [COUNT_WIDTH-1:0] r_sent    [NUM_LANES];
  logic [COUNT_WIDTH-1:0] r_recv    [NUM_LANES];
  logic [COUNT_WIDTH-1:0] r_exp_seq [NUM_LANES];
  logic [COUNT_WIDTH-1:0] r_num_msgs, r_err_count;
  logic [IDX_WIDTH-1:0]   r_last_gnt, r_first_err_lane;
  logic [IDLE_W-1:0]      r_idle;

  logic [NUM_LANES-1:0]  w_req, w_gnt, w_pend;
  logic [IDX_WIDTH-1:0]  w_gnt_idx, w_pend_idx, w_hl, w_err_lane;
  logic [DATA_WIDTH-1:0] w_exp_v;
  logic w_any, w_base_rdy, w_accept, w_lane_ok, w_heard_err, w_idle_tick;
  logic w_timeout, w_err, w_say_fire, w_start;

  rr_arbiter #(.N(NUM_LANES), .IDX_W(IDX_WIDTH)) u_arb (
    .i_req     (w_req),
    .i_last    (r_last_gnt),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  always_comb begin
    w_pend_idx = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      w_req[l]  = r_sent[l] < r_num_msgs;
      w_pend[l] = r_recv[l] != r_sent[l];
    end
    for (int l = NUM_LANES - 1; l >= 0; l--)
      if (w_pend[l]) w_pend_idx = IDX_WIDTH'(l);
  end

  assign w_start    = start && (r_state == IDLE || r_state == DONE);
  assign w_say_fire = (r_state == SEND) && w_any && say__RDY;
  assign say__ENA   = w_say_fire;
  assign say_meth   = w_gnt_idx;
  assign say_v      = DATA_WIDTH'(pack_payload(LANE_TAG_W'(w_gnt_idx),
                                               64'(r_sent[w_gnt_idx]), DATA_WIDTH));

  assign w_base_rdy = (r_state == SEND) || (r_state == DRAIN);
  assign w_accept   = heard__ENA && heard__RDY;
  assign w_lane_ok  = int'(heard_meth) < NUM_LANES;
  assign w_hl       = w_lane_ok ? heard_meth : '0;
  assign w_exp_v    = DATA_WIDTH'(pack_payload(LANE_TAG_W'(w_hl),
                                               64'(r_exp_seq[w_hl]), DATA_WIDTH));
  // An indication on a lane with nothing outstanding is unsolicited.
  assign w_heard_err = w_accept && (!w_lane_ok || !w_pend[w_hl] || heard_v != w_exp_v);

`ifdef IVECTOR_INIT_BACKPRESSURE_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge CLK) begin
    if (!nRST) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign heard__RDY  = w_base_rdy & r_lfsr[0];
  assign w_idle_tick = (r_state == DRAIN) && heard__RDY && !w_accept;
`else
  assign heard__RDY  = w_base_rdy;
  assign w_idle_tick = (r_state == DRAIN) && !w_accept;
`endif

  assign w_timeout  = w_idle_tick && (|w_pend) && (r_idle == IDLE_W'(TIMEOUT - 1));
  assign w_err      = w_heard_err || w_timeout;
  assign w_err_lane = w_timeout ? w_pend_idx : heard_meth;

  always_ff @(posedge CLK) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = SEND;
      SEND:       if (!w_any) w_state_nxt = DRAIN;
      DRAIN:      if (!(|w_pend) || w_timeout) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST || w_start) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        r_sent[l]    <= '0;
        r_recv[l]    <= '0;
        r_exp_seq[l] <= '0;
      end
      r_num_msgs       <= nRST ? num_msgs : '0;
      r_last_gnt       <= IDX_WIDTH'(NUM_LANES - 1);
      r_idle           <= '0;
      r_err_count      <= '0;
      r_first_err_lane <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (w_say_fire && w_gnt[l]) r_sent[l] <= r_sent[l] + c_cnt_one;
        if (w_accept && w_lane_ok && w_hl == IDX_WIDTH'(l)) begin
          r_recv[l]    <= r_recv[l] + c_cnt_one;
          r_exp_seq[l] <= r_exp_seq[l] + c_cnt_one;
        end
      end
      if (w_say_fire) r_last_gnt <= w_gnt_idx;
      if (r_state != DRAIN || w_accept) r_idle <= '0;
      else if (w_idle_tick)             r_idle <= r_idle + IDLE_W'(1);
      if (w_err) begin
        if (r_err_count != '1) r_err_count <= r_err_count + c_cnt_one;
        if (r_err_count == '0) r_first_err_lane <= w_err_lane;
      end
    end
  end

  assign busy           = w_base_rdy;
  assign done           = (r_state == DONE);
  assign err_count      = r_err_count;
  assign first_err_lane = r_first_err_lane;

endmodule

`default_nettype wire
